mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage (lw/sw) of the pipelined MIPS core.
- Grants one requester at a time and registers the winning address, write data, write enable and byte enables onto the memory port.
- Handles variable memory latency through mem_rdy and returns a one-cycle ack with read data.
- Generates the fetch and data stall signals consumed by the pipeline hazard logic; a watchdog aborts hung accesses.

Parameters:
- ADDR_W, 32, width of all address buses.
- TO_CYCLES, 255, wait cycles without mem_rdy before a transaction is aborted (range 1..65535).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  32  fetched instruction word.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request, level, held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  4  byte enables for stores.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access valid.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- mem_rdy  in  1  memory completes the current access this cycle.
- if_stall  out  1  equals if_req & ~if_ack (combinational).
- dm_stall  out  1  equals dm_req & ~dm_ack (combinational).
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values:
  - state IDLE.
  - mem_req, mem_we, if_ack, dm_ack, bus_err: 0.
  - mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata: 0.
  - last-grant flag: fetch.
  - Reset asserted mid-transaction drops mem_req immediately (asynchronously) and loses the transaction; no ack is issued.
- States: IDLE, IF_BUSY, DM_BUSY, DONE.
- IDLE:
  - dm_req=1: latch dm_addr/dm_wdata/dm_we/dm_be onto the mem_* registers, set mem_req=1, go to DM_BUSY.
  - Otherwise, if_req=1: latch if_addr with mem_we=0 and mem_be=4'hF, set mem_req=1, go to IF_BUSY.
  - Neither: stay in IDLE.
- *_BUSY:
  - mem_rdy=1: clear mem_req and mem_we.
  - For a fetch, capture mem_rdata into if_rdata. For a load, capture it into dm_rdata. A store leaves dm_rdata unchanged.
  - Pulse the matching ack for exactly one cycle and go to DONE.
  - mem_rdy=0: increment the wait counter.
  - Wait counter reaches TO_CYCLES: abort the access. Clear mem_req, load the rdata of the granted port with 32'hDEADBEEF (loads and fetches only), set bus_err, pulse ack, go to DONE.
- DONE: requests are not sampled; go to IDLE unconditionally. Requesters drop req on the cycle they see ack.
- Latency and throughput:
  - req sampled at edge 0 → mem_req high after edge 0.
  - mem_rdy=1 in that first cycle → ack high after edge 1.
  - Minimum 3 cycles per transaction.
- mem_addr/mem_wdata/mem_be are stable throughout BUSY regardless of requester input changes.
- The wait counter clears on every grant.
- bus_err clears only on reset.
- Simultaneous requests in IDLE: data wins (it is the older instruction).
- mem_rdy outside BUSY is ignored.

Optional Feature:
- ARB_RR_EN defined: when both requests are pending in IDLE, grant the requester not served last (last-grant flag updates on each grant). This bounds fetch wait to one data transaction.
- ARB_RR_EN undefined: fixed data priority; the last-grant flag is absent.

Decomposition:
- Shared package/header (mem_arb_def):
  - State encodings: IDLE=2'b00, IF_BUSY=2'b01, DM_BUSY=2'b10, DONE=2'b11.
  - Grant IDs: GNT_IF / GNT_DM.
  - ABORT_DATA=32'hDEADBEEF.
- One sub-module, arb_wait_timer: counter with clear, enable and terminal-count output parameterised by TO_CYCLES.

Test Plan:
- Fetch only: if_req=1 with if_addr=0x00003000, mem_rdy on the first BUSY cycle with mem_rdata=0x2008000A → mem_req for 1 cycle, if_ack 2 cycles after request, if_rdata=0x2008000A, if_stall low in the ack cycle.
- Store with wait states: dm_req=1, dm_we=1, dm_be=4'hF, addr 0x10, wdata 0x12345678, mem_rdy after 3 wait cycles → mem_addr/mem_wdata stable for 4 cycles, dm_ack once, dm_rdata unchanged.
- Collision: if_req and dm_req both rise at the same edge → data served first, fetch granted after DONE, if_stall high for ≥5 cycles. With ARB_RR_EN and a repeated collision, fetch wins the second round.
- Timeout: TO_CYCLES=4, load with mem_rdy held 0 → ack after 4 wait cycles, dm_rdata=0xDEADBEEF, bus_err=1 and remaining set until rstn.
- Reset mid-access: rstn low during DM_BUSY → mem_req 0 without waiting for a clock edge; after release, state is IDLE, no ack, bus_err 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter: FSM state
// encodings, grant identifiers and the data word returned on an aborted
// (timed-out) read.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      IF_BUSY = 2'b01,
      DM_BUSY = 2'b10,
      DONE    = 2'b11
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } arb_gnt_e;

   localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and memory port signals of the
// arbiter.
//   slave  : arbiter view (requests / memory responses in, grants out)
//   master : environment view (pipeline stages and memory model)
// Fetch side  : if_req, if_addr -> if_rdata, if_ack, if_stall
// Data side   : dm_req, dm_we, dm_be, dm_addr, dm_wdata -> dm_rdata, dm_ack,
//               dm_stall
// Memory side : mem_req, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata,
//               mem_rdy
// Status      : bus_err (sticky timeout flag)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ack;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [3:0]        dm_be;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [31:0]       dm_rdata;
   logic              dm_ack;
   logic              dm_stall;

   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_rdy;

   logic              bus_err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
             mem_rdata, mem_rdy,
      output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
             mem_rdata, mem_rdy,
      input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
   );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// ----------------------------------------------------------------------------
// arb_wait_timer
// Counts memory wait cycles of the access in flight.
//   clk, rstn : clock, asynchronous active-low reset
//   i_clr     : hold the count at zero (asserted whenever no access is busy)
//   i_en      : count one wait cycle
//   o_tc      : this is the TO_CYCLES-th wait cycle; the access is aborted at
//               the end of it unless memory answers
// ----------------------------------------------------------------------------
module arb_wait_timer #(
   parameter int TO_CYCLES = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int CNT_W = $clog2(TO_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;

   // The count holds at the terminal value; the FSM leaves BUSY on that cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == CNT_W'(TO_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch and the
// data-memory stage. One requester is granted at a time; the winning request
// is registered onto the memory port and held stable until mem_rdy, then a
// one-cycle ack returns the read data. A watchdog aborts accesses that wait
// TO_CYCLES cycles without mem_rdy, returning ABORT_DATA and setting the
// sticky bus_err flag.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (fetch, data and memory port signals)
// Optional build macro ARB_RR_EN: on simultaneous requests grant the
// requester not served last; otherwise data always wins.
// ----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int TO_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rstn,
   mem_port_arbiter_if.slave    bus
);

   arb_state_e        r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [3:0]        r_mem_be;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [31:0]       r_if_rdata;
   logic [31:0]       r_dm_rdata;
   logic              r_if_ack;
   logic              r_dm_ack;
   logic              r_bus_err;
`ifdef ARB_RR_EN
   arb_gnt_e          r_last_gnt;
`endif

   logic              w_busy;
   logic              w_tc;
   arb_gnt_e          w_gnt;

   assign w_busy = (r_state == IF_BUSY) || (r_state == DM_BUSY);

   // Grant choice, only meaningful when at least one request is pending.
   always_comb begin
      w_gnt = GNT_DM;
`ifdef ARB_RR_EN
      if (bus.dm_req && bus.if_req) begin
         w_gnt = (r_last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
      end else if (!bus.dm_req) begin
         w_gnt = GNT_IF;
      end
`else
      if (!bus.dm_req) begin
         w_gnt = GNT_IF;
      end
`endif
   end

   arb_wait_timer #(
      .TO_CYCLES (TO_CYCLES)
   ) u_wait_timer (
      .clk   (clk),
      .rstn  (rstn),
      .i_clr (!w_busy),
      .i_en  (w_busy && !bus.mem_rdy),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'h0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_bus_err   <= 1'b0;
`ifdef ARB_RR_EN
         r_last_gnt  <= GNT_IF;
`endif
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.dm_req || bus.if_req) begin
                  r_mem_req <= 1'b1;
`ifdef ARB_RR_EN
                  r_last_gnt <= w_gnt;
`endif
                  if (w_gnt == GNT_DM) begin
                     r_mem_addr  <= bus.dm_addr;
                     r_mem_wdata <= bus.dm_wdata;
                     r_mem_we    <= bus.dm_we;
                     r_mem_be    <= bus.dm_be;
                     r_state     <= DM_BUSY;
                  end else begin
                     r_mem_addr  <= bus.if_addr;
                     r_mem_we    <= 1'b0;
                     r_mem_be    <= 4'hF;
                     r_state     <= IF_BUSY;
                  end
               end
            end
            IF_BUSY, DM_BUSY: begin
               if (bus.mem_rdy) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  if (r_state == IF_BUSY) begin
                     r_if_rdata <= bus.mem_rdata;
                     r_if_ack   <= 1'b1;
                  end else begin
                     if (!r_mem_we) r_dm_rdata <= bus.mem_rdata;
                     r_dm_ack <= 1'b1;
                  end
                  r_state <= DONE;
               end else if (w_tc) begin
                  // Watchdog abort: complete the handshake with poison data.
                  r_mem_req <= 1'b0;
                  r_bus_err <= 1'b1;
                  if (r_state == IF_BUSY) begin
                     r_if_rdata <= ABORT_DATA;
                     r_if_ack   <= 1'b1;
                  end else begin
                     if (!r_mem_we) r_dm_rdata <= ABORT_DATA;
                     r_dm_ack <= 1'b1;
                  end
                  r_state <= DONE;
               end
            end
            // Requesters drop req while the ack is visible; do not resample.
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_be    = r_mem_be;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.if_ack    = r_if_ack;
   assign bus.dm_ack    = r_dm_ack;
   assign bus.bus_err   = r_bus_err;
   assign bus.if_stall  = bus.if_req & ~r_if_ack;
   assign bus.dm_stall  = bus.dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (TO_CYCLES = 4): a table of single
// transactions with hand-computed results, followed by hand-written
// sequences for watchdog abort, request collision and reset mid-access.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic rstn;
   int   total;
   int   bad;
   int   stall_cnt;

   mem_port_arbiter_if #(.ADDR_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W    (32),
      .TO_CYCLES (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_dm;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_if_rdata;
      logic [31:0] exp_dm_rdata;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.if_stall) stall_cnt++;
   endtask

   task automatic run_vec(input vec_t v, input int idx, input logic exp_err);
      string p;
      p = $sformatf("v%0d", idx);
      if (v.is_dm) begin
         bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_be = v.be;
         bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      step();
      chk({p, ".grant_mem_req"}, {31'b0, bus.mem_req}, 32'd1);
      chk({p, ".mem_addr"}, bus.mem_addr, v.addr);
      chk({p, ".mem_we"}, {31'b0, bus.mem_we}, {31'b0, v.is_dm & v.we});
      chk({p, ".mem_be"}, {28'b0, bus.mem_be}, {28'b0, v.exp_be});
      if (v.is_dm && v.we) chk({p, ".mem_wdata"}, bus.mem_wdata, v.wdata);
      for (int w = 0; w < v.waits; w++) begin
         // Requester inputs wander; the memory port must not follow them.
         bus.dm_addr = ~v.addr; bus.if_addr = ~v.addr; bus.dm_wdata = ~v.wdata;
         step();
         chk({p, ".wait_mem_addr"}, bus.mem_addr, v.addr);
         if (v.is_dm && v.we) chk({p, ".wait_mem_wdata"}, bus.mem_wdata, v.wdata);
         chk({p, ".wait_no_ack"}, {30'b0, bus.if_ack, bus.dm_ack}, 32'd0);
      end
      bus.mem_rdy = 1'b1; bus.mem_rdata = v.rdata;
      step();
      bus.mem_rdy = 1'b0;
      chk({p, ".ack"}, {30'b0, bus.if_ack, bus.dm_ack}, v.is_dm ? 32'd1 : 32'd2);
      chk({p, ".if_rdata"}, bus.if_rdata, v.exp_if_rdata);
      chk({p, ".dm_rdata"}, bus.dm_rdata, v.exp_dm_rdata);
      chk({p, ".done_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
      chk({p, ".stall_in_ack"}, {30'b0, bus.if_stall, bus.dm_stall}, 32'd0);
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      step();
      chk({p, ".ack_pulse"}, {30'b0, bus.if_ack, bus.dm_ack}, 32'd0);
      chk({p, ".bus_err"}, {31'b0, bus.bus_err}, {31'b0, exp_err});
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      //                is_dm we  be     addr          wdata         w  rdata         exp_be  exp_if        exp_dm
      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_3000, 32'h0,         0, 32'h2008_000A, 4'hF, 32'h2008_000A, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 3, 32'hFFFF_FFFF, 4'hF, 32'h2008_000A, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         1, 32'h1234_5678, 4'hF, 32'h2008_000A, 32'h1234_5678};
      vecs[3] = '{1'b1, 1'b1, 4'h3, 32'h0000_0024, 32'hA5A5_5A5A, 0, 32'h0,         4'h3, 32'h2008_000A, 32'h1234_5678};
      vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_3004, 32'h0,         2, 32'h8C09_0010, 4'hF, 32'h8C09_0010, 32'h1234_5678};
      vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_0024, 32'h0,         3, 32'h0000_5A5A, 4'hF, 32'h8C09_0010, 32'h0000_5A5A};

      total = 0; bad = 0; stall_cnt = 0;
      rstn = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
      bus.dm_addr = '0; bus.dm_wdata = '0;
      bus.mem_rdata = '0; bus.mem_rdy = 1'b0;

      // Reset state
      step(); step();
      chk("rst.mem_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst.mem_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst.acks", {30'b0, bus.if_ack, bus.dm_ack}, 32'd0);
      chk("rst.bus_err", {31'b0, bus.bus_err}, 32'd0);
      chk("rst.mem_be", {28'b0, bus.mem_be}, 32'd0);
      chk("rst.mem_addr", bus.mem_addr, 32'd0);
      chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst.if_rdata", bus.if_rdata, 32'd0);
      chk("rst.dm_rdata", bus.dm_rdata, 32'd0);
      rstn = 1'b1;
      step();

      // Single transactions
      for (int i = 0; i < 6; i++) run_vec(vecs[i], i, 1'b0);

      // Watchdog: load with no mem_rdy aborts after 4 wait cycles
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h80;
      step();
      chk("to.mem_req", {31'b0, bus.mem_req}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("to.no_ack%0d", i), {31'b0, bus.dm_ack}, 32'd0);
      end
      step();
      chk("to.dm_ack", {31'b0, bus.dm_ack}, 32'd1);
      chk("to.dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
      chk("to.bus_err", {31'b0, bus.bus_err}, 32'd1);
      chk("to.mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
      chk("to.if_rdata_kept", bus.if_rdata, 32'h8C09_0010);
      bus.dm_req = 1'b0;
      step(); step();
      chk("to.bus_err_sticky", {31'b0, bus.bus_err}, 32'd1);

      // Collision: data wins first; a fresh data request then meets the
      // still-pending fetch
      stall_cnt = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h3008;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
      #1;
      if (bus.if_stall) stall_cnt++;
      step();
      chk("col.first_addr", bus.mem_addr, 32'h40);
      bus.mem_rdy = 1'b1; bus.mem_rdata = 32'h1111_1111;
      step();
      bus.mem_rdy = 1'b0;
      chk("col.dm_ack1", {30'b0, bus.if_ack, bus.dm_ack}, 32'd1);
      chk("col.dm_rdata1", bus.dm_rdata, 32'h1111_1111);
      bus.dm_req = 1'b0;
      step();
      bus.dm_req = 1'b1; bus.dm_addr = 32'h44;
      step();
`ifdef ARB_RR_EN
      chk("col.rr_fetch_wins", bus.mem_addr, 32'h3008);
      bus.mem_rdy = 1'b1; bus.mem_rdata = 32'h2222_2222;
      step();
      bus.mem_rdy = 1'b0;
      chk("col.if_ack", {30'b0, bus.if_ack, bus.dm_ack}, 32'd2);
      chk("col.if_rdata", bus.if_rdata, 32'h2222_2222);
      bus.if_req = 1'b0;
      step(); step();
      chk("col.dm_second", bus.mem_addr, 32'h44);
      bus.mem_rdy = 1'b1; bus.mem_rdata = 32'h3333_3333;
      step();
      bus.mem_rdy = 1'b0;
      chk("col.dm_ack2", {30'b0, bus.if_ack, bus.dm_ack}, 32'd1);
      bus.dm_req = 1'b0;
      chk("col.if_stall_cycles", {31'b0, stall_cnt >= 5}, 32'd1);
`else
      chk("col.data_again", bus.mem_addr, 32'h44);
      bus.mem_rdy = 1'b1; bus.mem_rdata = 32'h3333_3333;
      step();
      bus.mem_rdy = 1'b0;
      chk("col.dm_ack2", {30'b0, bus.if_ack, bus.dm_ack}, 32'd1);
      chk("col.dm_rdata2", bus.dm_rdata, 32'h3333_3333);
      bus.dm_req = 1'b0;
      step(); step();
      chk("col.fetch_last", bus.mem_addr, 32'h3008);
      bus.mem_rdy = 1'b1; bus.mem_rdata = 32'h2222_2222;
      step();
      bus.mem_rdy = 1'b0;
      chk("col.if_ack", {30'b0, bus.if_ack, bus.dm_ack}, 32'd2);
      chk("col.if_rdata", bus.if_rdata, 32'h2222_2222);
      bus.if_req = 1'b0;
      chk("col.if_stall_cycles", {31'b0, stall_cnt >= 5}, 32'd1);
`endif
      step(); step();

      // Reset mid-access: mem_req drops without a clock edge
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'hF;
      bus.dm_addr = 32'h50; bus.dm_wdata = 32'hCAFE_F00D;
      step();
      chk("rma.mem_req", {31'b0, bus.mem_req}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("rma.async_drop", {31'b0, bus.mem_req}, 32'd0);
      chk("rma.bus_err_clr", {31'b0, bus.bus_err}, 32'd0);
      bus.dm_req = 1'b0;
      step();
      rstn = 1'b1;
      bus.mem_rdy = 1'b1;
      step();
      bus.mem_rdy = 1'b0;
      chk("rma.no_ack", {30'b0, bus.if_ack, bus.dm_ack}, 32'd0);
      chk("rma.idle", {31'b0, bus.mem_req}, 32'd0);
      step();
      run_vec(vecs[0], 10, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
